seq_mult_256bit: RTL and testbench
==================================

# seq_mult_256bit

Sequential unsigned 256×256-bit multiplier producing a full 512-bit product. It uses a radix-2 shift-and-add datapath, one multiplier bit per clock. It is the shared low-area multiply primitive for the ed25519 field and scalar arithmetic blocks; modular reduction is done downstream. Operands are latched on a start pulse, and completion is signalled by a one-cycle done pulse.

## Interface
- No parameters; widths are fixed (operands 256, product 512).
- clk    input   1    rising-edge clock
- rst_n  input   1    asynchronous, active-low reset
- a      input   256  multiplicand, unsigned; sampled only on an accepted start
- b      input   256  multiplier, unsigned; sampled only on an accepted start
- start  input   1    request; accepted only when idle
- product output 512  registered result a×b; holds its value until the next completion
- done   output  1    one-cycle pulse; product is valid in and after this cycle

## Operation
- Reset (rst_n low, asynchronous):
  - state = IDLE, product = 0, done = 0.
  - Internal operand registers, accumulator and counter cleared.
- IDLE:
  - done = 0.
  - If start is high at a rising edge: latch A=a (zero-extended to 512), B=b, clear accumulator and counter, go to BUSY.
- BUSY, one iteration per cycle:
  - If B[0] is set: acc = acc + A (512-bit add, cannot overflow).
  - Then A <<= 1, B >>= 1, count++.
  - After the 256th iteration: product = acc (final value, including the last add), go to DONE.
- DONE, one cycle:
  - done = 1.
  - Next state is IDLE unconditionally.
- start while in BUSY or DONE is ignored and not queued.
- Changes on a/b after acceptance have no effect on the running operation.
- product is written only on the BUSY→DONE transition. It is never a partial sum, and it stays stable through IDLE until the next operation completes.
- Arithmetic:
  - Purely unsigned; no sign handling.
  - The result is exact for all inputs, including 0 and 2^256−1.
  - Counter is 9 bits (0..256) or an equivalent terminal-count scheme.
- Optional early termination is not allowed: latency is constant, independent of operand values.

## Timing
- Edge 0: start sampled high in IDLE.
- Edges 1..256: the 256 BUSY iterations. On edge 256 the design enters DONE and product updates.
- done is high from edge 256 to edge 257, and falls at edge 257 (state returns to IDLE).
- Latency from accepting edge to done rising: 256 clocks. The done pulse is exactly 1 cycle wide.
- Throughput: a new start can be accepted at edge 258 at the earliest (first IDLE cycle). Issue rate is therefore one operation per 258 cycles.
- Falling edge of done is a valid point to sample product; product equals a×b from edge 256 onward.
- Reset mid-operation: the operation is aborted immediately; done stays 0, product = 0, state = IDLE. No done pulse is produced for the aborted operation.
- start held high continuously: a new operation begins every 258 cycles, using the a/b present at each accepting edge.

## Test plan
- a=2, b=2, one-cycle start → done pulses once, 256 cycles after the accepting edge; product=4 at done's falling edge.
- a=0, b=2^256−1 and a=2^256−1, b=0 → product=0; done timing identical to the first case.
- a=b=2^256−1 → product = 2^512 − 2^257 + 1; checks full-width carries.
- Random 256-bit a, b, 50 runs, back-to-back with start reasserted in the first IDLE cycle → each product matches the reference a×b. Toggling a/b and pulsing start during BUSY must not alter the result or add done pulses.
- Assert rst_n low 100 cycles into an operation → product=0, done=0 immediately; no done pulse follows. A fresh start afterwards yields the correct result.
- Power-up reset with no start → done stays 0 and product stays 0 indefinitely.

Source files
------------

// File: rtl/seq_mult_256bit.sv
// seq_mult_256bit: unsigned 256x256 -> 512-bit shift-and-add multiplier.
// Processes one multiplier bit per clock. Latency is a constant 256 clocks
// from the accepting edge to done. done is a single-cycle pulse.
module seq_mult_256bit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] a,
    input  logic [255:0] b,
    input  logic         start,
    output logic [511:0] product,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic [511:0] a_reg;   // multiplicand, shifted left each iteration
    logic [255:0] b_reg;   // multiplier, shifted right each iteration
    logic [511:0] acc;
    logic [8:0]   count;

    logic [511:0] sum;     // accumulator value after this iteration's add
    logic         last;    // current BUSY cycle is the 256th iteration

    // Next-state logic, the done output, and the iteration adder.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        last      = (count == 9'd255);
        sum       = acc + (b_reg[0] ? a_reg : '0);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, shift-and-add iteration, and product capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= {256'd0, a};
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                BUSY: begin
                    acc   <= sum;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    count <= count + 9'd1;
                    // The last iteration's add is taken straight from the
                    // adder so product is never left one term short.
                    if (last) begin
                        product <= sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_256bit.sv
// Testbench for seq_mult_256bit: directed and random operands, checked
// against a plain a*b reference, plus latency and reset behaviour.
module tb_seq_mult_256bit;

    logic         clk;
    logic         rst_n;
    logic [255:0] a;
    logic [255:0] b;
    logic         start;
    logic [511:0] product;
    logic         done;

    int unsigned vectors;
    int unsigned miscompares;

    logic [255:0] max256;
    logic [511:0] expect_max;

    seq_mult_256bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .start   (start),
        .product (product),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] xw;
        logic [511:0] yw;
        xw = {256'd0, x};
        yw = {256'd0, y};
        return xw * yw;
    endfunction

    task automatic check_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts one operation on the next rising edge (caller guarantees IDLE
    // there), optionally disturbs a/b/start while busy, and checks latency,
    // result, pulse width and product hold. Returns just before the first
    // IDLE edge so a following call issues back-to-back.
    task automatic do_op(input string tag, input logic [255:0] x, input logic [255:0] y,
                         input bit disturb, input bit chk_const, input logic [511:0] kconst);
        logic [511:0] exp;
        int n;
        exp   = ref_mul(x, y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);                  // accepting edge 0
        #1;
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            n = i;
            if (disturb) begin
                #1;
                a     = rand256();
                b     = rand256();
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (done) break;
        end
        start = 1'b0;
        check_int({tag, " latency"}, n, 256);
        check_int({tag, " done_high"}, int'(done), 1);
        check_vec({tag, " product@done"}, product, exp);
        if (chk_const) check_vec({tag, " product_const"}, product, kconst);
        @(posedge clk);                  // edge 257
        @(negedge clk);
        check_int({tag, " done_width"}, int'(done), 0);
        check_vec({tag, " product_hold"}, product, exp);
    endtask

    initial begin
        int highs;
        logic [511:0] prev;
        vectors     = 0;
        miscompares = 0;
        max256      = '1;
        expect_max  = 512'd0 - (512'd1 << 257) + 512'd1;
        a     = '0;
        b     = '0;
        start = 1'b0;
        rst_n = 1'b0;

        // Power-up reset, then idle with no start.
        repeat (3) @(negedge clk);
        check_vec("reset product", product, '0);
        check_int("reset done", int'(done), 0);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) highs++;
            if (product !== '0) highs++;
        end
        check_int("idle no activity", highs, 0);

        // Directed operands.
        do_op("two_x_two", 256'd2, 256'd2, 1'b0, 1'b1, 512'd4);
        do_op("zero_x_max", '0, max256, 1'b0, 1'b1, '0);
        do_op("max_x_zero", max256, '0, 1'b0, 1'b1, '0);
        do_op("max_x_max", max256, max256, 1'b0, 1'b1, expect_max);

        // Random back-to-back operations with busy-time disturbance.
        for (int r = 0; r < 50; r++) begin
            do_op($sformatf("rand%0d", r), rand256(), rand256(), 1'b1, 1'b0, '0);
        end

        // Reset 100 cycles into an operation.
        prev  = product;
        a     = rand256();
        b     = rand256();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("midreset prior product nonzero", int'(prev !== '0), 1);
        check_vec("midreset product", product, '0);
        check_int("midreset done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) highs++;
        end
        check_int("midreset no done", highs, 0);
        check_vec("midreset product stays", product, '0);

        // Fresh operation after the aborted one.
        do_op("after_reset", rand256(), rand256(), 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
